// File: rtl/mem_access_unit_pkg.sv
// Shared CPU pipeline definitions: data/register widths and the memory-stage FSM encoding.
// Also used by the EX/MEM and MEM/WB register blocks.
package mem_access_unit_pkg;

    localparam int CPU_DW = 16;
    localparam int CPU_RW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } mem_state_e;

    function automatic logic is_memop(input logic valid, input logic mem_read, input logic mem_write);
        return valid & (mem_read | mem_write);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// EX/MEM-side, data-memory and MEM/WB-side signals of the memory stage.
// The slave modport is the memory access unit; the master modport is its environment.
interface mem_access_unit_if #(
    parameter int DW = mem_access_unit_pkg::CPU_DW,
    parameter int RW = mem_access_unit_pkg::CPU_RW
);

    logic          ex_valid;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_reg_write;
    logic [DW-1:0] ex_alu_result;
    logic [DW-1:0] ex_rd1;
    logic [RW-1:0] ex_dstReg;
    logic          stall;

    logic          mem_en;
    logic          mem_wr;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_data_valid;

    logic          wb_valid;
    logic          wb_reg_write;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_dstReg;
    logic          mem_err;

    modport slave (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
               ex_alu_result, ex_rd1, ex_dstReg, mem_rdata, mem_data_valid,
        output stall, mem_en, mem_wr, mem_addr, mem_wdata,
               wb_valid, wb_reg_write, wb_data, wb_dstReg, mem_err
    );

    modport master (
        output ex_valid, ex_mem_read, ex_mem_write, ex_reg_write,
               ex_alu_result, ex_rd1, ex_dstReg, mem_rdata, mem_data_valid,
        input  stall, mem_en, mem_wr, mem_addr, mem_wdata,
               wb_valid, wb_reg_write, wb_data, wb_dstReg, mem_err
    );

endinterface

// File: rtl/mem_access_unit_timeout_ctr.sv
// Memory-access timeout counter: load to 1, increment, flag when TIMEOUT_CYCLES-1 is reached.
// The bound stays below 256, so the 8-bit count never wraps.
module mem_access_unit_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_inc,
    output logic o_tc
);

    logic [7:0] r_count;

    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= 8'd1;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_tc = (r_count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues loads/stores to a multi-cycle data memory, stalls upstream while busy,
// drives registered MEM/WB outputs. Optional MEM_ALIGN_CHECK_EN faults odd addresses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DW             = CPU_DW,
    parameter int RW             = CPU_RW,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_unit_if.slave  bus
);

    mem_state_e    r_state;
    mem_state_e    w_state_nxt;

    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [RW-1:0] r_dst;
    logic          r_reg_write;
    logic          r_load;

    logic          r_wb_valid;
    logic          r_wb_reg_write;
    logic [DW-1:0] r_wb_data;
    logic [RW-1:0] r_wb_dst;
    logic          r_mem_err;

    logic          w_wb_valid_nxt;
    logic          w_wb_reg_write_nxt;
    logic [DW-1:0] w_wb_data_nxt;
    logic [RW-1:0] w_wb_dst_nxt;
    logic          w_mem_err_nxt;

    logic          w_memop;
    logic          w_misaligned;
    logic [DW-1:0] w_addr_in;
    logic          w_capture;
    logic          w_stall;
    logic          w_ctr_load;
    logic          w_ctr_inc;
    logic          w_ctr_tc;

    assign w_memop = is_memop(bus.ex_valid, bus.ex_mem_read, bus.ex_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_memop & bus.ex_alu_result[0];
    assign w_addr_in    = bus.ex_alu_result;
`else
    assign w_misaligned = 1'b0;
    assign w_addr_in    = {bus.ex_alu_result[DW-1:1], 1'b0};
`endif

    mem_access_unit_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ctr_load),
        .i_inc  (w_ctr_inc),
        .o_tc   (w_ctr_tc)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
        w_state_nxt        = r_state;
        w_wb_valid_nxt     = 1'b0;
        w_wb_reg_write_nxt = 1'b0;
        w_wb_data_nxt      = r_wb_data;
        w_wb_dst_nxt       = r_wb_dst;
        w_mem_err_nxt      = 1'b0;
        w_capture          = 1'b0;
        w_stall            = 1'b0;
        w_ctr_load         = 1'b0;
        w_ctr_inc          = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_memop) begin
                    w_stall   = 1'b1;
                    w_capture = 1'b1;
                    if (w_misaligned) begin
                        w_state_nxt    = RESP;
                        w_wb_valid_nxt = 1'b1;
                        w_wb_data_nxt  = '0;
                        w_wb_dst_nxt   = bus.ex_dstReg;
                        w_mem_err_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = REQ;
                    end
                end else if (bus.ex_valid) begin
                    w_wb_valid_nxt     = 1'b1;
                    w_wb_reg_write_nxt = bus.ex_reg_write;
                    w_wb_data_nxt      = bus.ex_alu_result;
                    w_wb_dst_nxt       = bus.ex_dstReg;
                end
            end

            REQ, WAIT: begin
                w_stall    = 1'b1;
                w_ctr_load = (r_state == REQ);
                w_ctr_inc  = (r_state == WAIT);
                // A response in the same cycle as the timeout bound still completes normally.
                if (bus.mem_data_valid) begin
                    w_state_nxt        = RESP;
                    w_wb_valid_nxt     = 1'b1;
                    w_wb_dst_nxt       = r_dst;
                    w_wb_reg_write_nxt = r_load & r_reg_write;
                    w_wb_data_nxt      = r_load ? bus.mem_rdata : r_addr;
                end else if (r_state == REQ) begin
                    w_state_nxt = WAIT;
                end else if (w_ctr_tc) begin
                    w_state_nxt    = RESP;
                    w_wb_valid_nxt = 1'b1;
                    w_wb_dst_nxt   = r_dst;
                    w_wb_data_nxt  = '0;
                    w_mem_err_nxt  = 1'b1;
                end
            end

            RESP: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= '0;
            r_wb_dst       <= '0;
            r_mem_err      <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_wb_valid     <= w_wb_valid_nxt;
            r_wb_reg_write <= w_wb_reg_write_nxt;
            r_wb_data      <= w_wb_data_nxt;
            r_wb_dst       <= w_wb_dst_nxt;
            r_mem_err      <= w_mem_err_nxt;
        end
    end

    // Holding registers feed the memory request, so they are cleared to keep mem_addr/mem_wdata at 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_dst       <= '0;
            r_reg_write <= 1'b0;
            r_load      <= 1'b0;
        end else if (w_capture) begin
            r_addr      <= w_addr_in;
            r_wdata     <= bus.ex_rd1;
            r_dst       <= bus.ex_dstReg;
            r_reg_write <= bus.ex_reg_write;
            r_load      <= bus.ex_mem_read;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.mem_en       = (r_state == REQ);
    assign bus.mem_wr       = (r_state == REQ) & ~r_load;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_wdata    = r_wdata;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_reg_write = r_wb_reg_write;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_dstReg    = r_wb_dst;
    assign bus.mem_err      = r_mem_err;

endmodule
